// File: rtl/sc_sched_pkg.sv
// Shared types and constants for the register write-back scheduler.
package sc_sched_pkg;
  localparam int NREQ  = 3;
  localparam int CNT_W = 2;

  typedef logic [CNT_W-1:0] pend_cnt_t;
  localparam pend_cnt_t PEND_MAX = 2'd3;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LW  = 2'd1,
    REQ_DBG = 2'd2
  } req_id_e;

  // Successor in the 3-way rotation (mod 3).
  function automatic req_id_e next_id(input req_id_e id);
    case (id)
      REQ_ALU: next_id = REQ_LW;
      REQ_LW:  next_id = REQ_DBG;
      default: next_id = REQ_ALU;
    endcase
  endfunction
endpackage

// File: rtl/rr_arbiter3.sv
// 3-way round-robin arbiter: priority pointer plus combinational one-hot grant.
module rr_arbiter3
  import sc_sched_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output req_id_e         winner,
  output logic            any
);
  req_id_e ptr, c1, c2;

  always_comb begin
    c1     = next_id(ptr);
    c2     = next_id(c1);
    winner = ptr;
    any    = 1'b1;
    if (valid[ptr])     winner = ptr;
    else if (valid[c1]) winner = c1;
    else if (valid[c2]) winner = c2;
    else                any    = 1'b0;
    grant = any ? (NREQ'(1) << winner) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    ptr <= REQ_ALU;
    else if (any) ptr <= next_id(winner);
  end
endmodule

// File: rtl/reg_wb_sched.sv
// Write-back scheduler: round-robin write-port sharing, registered write stage,
// per-register pending scoreboard. Optional bypass under REG_WB_SCHED_BYPASS_EN.
module reg_wb_sched
  import sc_sched_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int DBITS               = 32,
  parameter int NREGS               = 2**REG_INDEX_BIT_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ*REG_INDEX_BIT_WIDTH-1:0] req_idx,
  input  logic [NREQ*DBITS-1:0]               req_data,
  input  logic                                iss_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]      iss_rd,
  output logic                                iss_ready,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]      rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]      rs2,
  output logic                                hazard,
  output logic                                wr_en,
  output logic [REG_INDEX_BIT_WIDTH-1:0]      wr_idx,
  output logic [DBITS-1:0]                    wr_data,
  output logic                                fwd1_en,
  output logic                                fwd2_en,
  output logic [DBITS-1:0]                    fwd_data,
  output logic [NREGS-1:0]                    busy
);
  localparam int RW = REG_INDEX_BIT_WIDTH;

  req_id_e   winner;
  logic      any;
  pend_cnt_t cnt [NREGS];

  rr_arbiter3 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  (req_valid),
    .grant  (req_ready),
    .winner (winner),
    .any    (any)
  );

  // The register file always consumes this stage; no backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= any;
      if (any) begin
        wr_idx  <= req_idx[int'(winner)*RW +: RW];
        wr_data <= req_data[int'(winner)*DBITS +: DBITS];
      end
    end
  end

  assign iss_ready = (cnt[iss_rd] != PEND_MAX);

  for (genvar r = 0; r < NREGS; r++) begin : g_sb
    logic inc, dec;
    assign inc = iss_valid & iss_ready & (iss_rd == RW'(r));
    // A write to an idle register (e.g. debug) must not underflow.
    assign dec = wr_en & (wr_idx == RW'(r)) & (cnt[r] != '0);
    assign busy[r] = (cnt[r] != '0);

    always_ff @(posedge clk or posedge reset) begin
      if (reset)            cnt[r] <= '0;
      else if (inc && !dec) cnt[r] <= cnt[r] + 1'b1;
      else if (dec && !inc) cnt[r] <= cnt[r] - 1'b1;
    end
  end

`ifdef REG_WB_SCHED_BYPASS_EN
  // Only the last outstanding write may be forwarded; older pending ones still stall.
  assign fwd1_en = wr_en & (wr_idx == rs1) & (cnt[rs1] == CNT_W'(1));
  assign fwd2_en = wr_en & (wr_idx == rs2) & (cnt[rs2] == CNT_W'(1));
`else
  assign fwd1_en = 1'b0;
  assign fwd2_en = 1'b0;
`endif

  assign fwd_data = wr_data;
  assign hazard   = (busy[rs1] & ~fwd1_en) | (busy[rs2] & ~fwd2_en);
endmodule

// File: tb/tb_reg_wb_sched.sv
// Self-checking bench for reg_wb_sched: directed scenarios plus random traffic
// against a behavioural model (round-robin search, pending-count array).
module tb_reg_wb_sched;
  localparam int RW = 4;
  localparam int DW = 32;
  localparam int NR = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req_valid, req_ready;
  logic [3*RW-1:0] req_idx;
  logic [3*DW-1:0] req_data;
  logic            iss_valid, iss_ready;
  logic [RW-1:0]   iss_rd, rs1, rs2;
  logic            hazard, wr_en, fwd1_en, fwd2_en;
  logic [RW-1:0]   wr_idx;
  logic [DW-1:0]   wr_data, fwd_data;
  logic [NR-1:0]   busy;

  reg_wb_sched #(.REG_INDEX_BIT_WIDTH(RW), .DBITS(DW), .NREGS(NR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_data(req_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd_data(fwd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // reference model state
  int          m_ptr;
  bit          m_en;
  int          m_idx;
  logic [31:0] m_data;
  int          cnt [NR];
  bit          byp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ptr = 0; m_en = 0; m_idx = 0; m_data = 0;
    for (int r = 0; r < NR; r++) cnt[r] = 0;
  endtask

  task automatic idle();
    req_valid = '0; iss_valid = 0;
  endtask

  // Check every output against the model, then advance one clock.
  task automatic step();
    int g, id, n_ptr, n_idx;
    bit f1, f2, hz, rdy, n_en;
    logic [31:0] n_data;
    logic [NR-1:0] eb;
    int ncnt [NR];
    #1;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      id = (m_ptr + k) % 3;
      if (g < 0 && req_valid[id]) g = id;
    end
    f1 = byp && m_en && (m_idx == int'(rs1)) && cnt[rs1] == 1;
    f2 = byp && m_en && (m_idx == int'(rs2)) && cnt[rs2] == 1;
    hz = (cnt[rs1] != 0 && !f1) || (cnt[rs2] != 0 && !f2);
    rdy = cnt[iss_rd] != 3;
    for (int r = 0; r < NR; r++) eb[r] = cnt[r] != 0;
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    chk("iss_ready", 32'(iss_ready), 32'(rdy));
    chk("hazard",    32'(hazard),    32'(hz));
    chk("fwd1_en",   32'(fwd1_en),   32'(f1));
    chk("fwd2_en",   32'(fwd2_en),   32'(f2));
    chk("wr_en",     32'(wr_en),     32'(m_en));
    chk("wr_idx",    32'(wr_idx),    32'(m_idx));
    chk("wr_data",   wr_data,        m_data);
    chk("fwd_data",  fwd_data,       m_data);
    chk("busy",      32'(busy),      32'(eb));
    for (int r = 0; r < NR; r++) ncnt[r] = cnt[r];
    if (iss_valid && rdy) ncnt[iss_rd] = ncnt[iss_rd] + 1;
    if (m_en && cnt[m_idx] > 0) ncnt[m_idx] = ncnt[m_idx] - 1;
    n_en = (g >= 0); n_idx = m_idx; n_data = m_data; n_ptr = m_ptr;
    if (g >= 0) begin
      n_idx  = int'(req_idx[g*RW +: RW]);
      n_data = req_data[g*DW +: DW];
      n_ptr  = (g + 1) % 3;
    end
    @(posedge clk);
    m_en = n_en; m_idx = n_idx; m_data = n_data; m_ptr = n_ptr;
    for (int r = 0; r < NR; r++) cnt[r] = ncnt[r];
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; idle();
    m_reset();
    @(posedge clk); @(negedge clk);
    reset = 0;
  endtask

  initial begin
`ifdef REG_WB_SCHED_BYPASS_EN
    byp = 1;
`else
    byp = 0;
`endif
    reset = 1; req_valid = '0; req_idx = '0; req_data = '0;
    iss_valid = 0; iss_rd = '0; rs1 = '0; rs2 = '0;
    m_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_iss_ready", 32'(iss_ready), 32'd1);
    reset = 0;

    // ALU writes r1=7 alone
    req_valid = 3'b001; req_idx[3:0] = 4'd1; req_data[31:0] = 32'd7;
    #1 chk("t1_rdy", 32'(req_ready), 32'b001);
    step();
    idle();
    chk("t1_en", 32'(wr_en), 32'd1);
    chk("t1_idx", 32'(wr_idx), 32'd1);
    chk("t1_data", wr_data, 32'd7);
    req_valid = 3'b111;
    #1 chk("t1_ptr1", 32'(req_ready), 32'b010);
    do_reset();

    // all three valid for 6 cycles
    req_idx  = {4'd3, 4'd2, 4'd1};
    req_data = {32'd2, 32'd9, 32'd5};
    for (int i = 0; i < 6; i++) begin
      req_valid = 3'b111;
      #1 chk("t2_rot", 32'(req_ready), 32'd1 << (i % 3));
      step();
    end
    idle(); step();

    // RAW hazard on r2 resolved by an ALU write
    iss_valid = 1; iss_rd = 4'd2; rs1 = 4'd2; rs2 = 4'd0;
    step();
    iss_valid = 0;
    #1 chk("t3_hz_issue", 32'(hazard), 32'd1);
    step(); step();
    req_valid = 3'b001; req_idx[3:0] = 4'd2; req_data[31:0] = 32'd9;
    step();
    idle();
    #1 chk("t3_hz_wr", 32'(hazard), byp ? 32'd0 : 32'd1);
    chk("t3_fwd1", 32'(fwd1_en), 32'(byp));
    chk("t3_fwd_data", fwd_data, 32'd9);
    step();
    chk("t3_hz_after", 32'(hazard), 32'd0);

    // saturate r4, then load write overlapping an issue
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1; iss_rd = 4'd4;
      #1 chk("t4_iss_ready", 32'(iss_ready), (i < 3) ? 32'd1 : 32'd0);
      step();
    end
    req_valid = 3'b010; req_idx[7:4] = 4'd4;
    step();
    req_valid = '0;
    chk("t4_busy4", 32'(busy[4]), 32'd1);
    step();
    idle(); step(); step(); step();

    // debug write to idle r5
    req_valid = 3'b100; req_idx[11:8] = 4'd5; req_data[95:64] = 32'hd00d;
    step(); idle(); step();
    chk("t5_busy5", 32'(busy[5]), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 3'($urandom);
      for (int q = 0; q < 3; q++) begin
        req_idx[q*RW +: RW]  = RW'($urandom_range(0, 7));
        req_data[q*DW +: DW] = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd = RW'($urandom_range(0, 7));
      rs1 = RW'($urandom_range(0, 7));
      rs2 = RW'($urandom_range(0, 7));
      step();
    end

    // reset mid-burst with pending counts
    iss_valid = 1; iss_rd = 4'd6; req_valid = 3'b111;
    step(); step();
    reset = 1;
    #1 chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_wr_en", 32'(wr_en), 32'd0);
    m_reset();
    idle();
    @(posedge clk); @(negedge clk);
    reset = 0;
    req_valid = 3'b111;
    #1 chk("t6_ptr0", 32'(req_ready), 32'b001);
    step(); idle(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
